// File: rtl/ucsbece154b_bpred_gshare_pkg.sv
// Shared encodings for the gshare predictor: BTB entry types and init-FSM states.
package ucsbece154b_bpred_gshare_pkg;

  typedef enum logic [1:0] {
    BT_BRANCH = 2'b00,
    BT_JUMP   = 2'b01,
    BT_CALL   = 2'b10,
    BT_RET    = 2'b11
  } bt_type_e;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_e;

endpackage

// File: rtl/ucsbece154b_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when BPRED_RAS_EN is defined.
module ucsbece154b_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;
  logic [31:0]   r_mem [DEPTH];

  assign empty_o = (r_count == '0);
  assign top_o   = r_mem[r_ptr - PTR_ONE];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push_i) begin
      r_ptr <= r_ptr + PTR_ONE;
      if (r_count != CNT_FULL) r_count <= r_count + CNT_ONE;
    end else if (pop_i && !empty_o) begin
      r_ptr   <= r_ptr - PTR_ONE;
      r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) r_mem[r_ptr] <= push_data_i;
  end

endmodule

// File: rtl/ucsbece154b_bpred_gshare.sv
// Fetch-stage predictor: direct-mapped BTB + gshare PHT with speculative GHR and
// post-reset PHT clearing. Define BPRED_RAS_EN to add a return-address stack.
module ucsbece154b_bpred_gshare
  import ucsbece154b_bpred_gshare_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int CTR_BITS        = 2,
  parameter int TAG_BITS        = 12,
  parameter int RAS_DEPTH       = 8
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  output logic                    ready_o,
  output logic                    dbg_state_o,
  input  logic                    fetch_valid_i,
  input  logic [31:0]             pc_i,
  output logic                    hit_o,
  output logic                    taken_o,
  output logic [31:0]             target_o,
  output logic [NUM_GHR_BITS-1:0] ghr_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [1:0]              upd_type_i,
  input  logic                    upd_taken_i,
  input  logic [31:0]             upd_target_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic                    upd_mispredict_i
);

  localparam int IDX       = $clog2(NUM_BTB_ENTRIES);
  localparam int N         = NUM_GHR_BITS;
  localparam int PHT_DEPTH = 2**N;
  localparam int TAG_LSB   = IDX + 2;
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]        CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]        CNT_LAST = {N{1'b1}};

  bp_state_e             r_state, w_state_next;
  logic [N-1:0]          r_cnt, r_ghr, w_ghr_next;
  logic [NUM_BTB_ENTRIES-1:0] r_valid;
  logic [TAG_BITS-1:0]   r_tag    [NUM_BTB_ENTRIES];
  logic [31:0]           r_target [NUM_BTB_ENTRIES];
  bt_type_e              r_type   [NUM_BTB_ENTRIES];
  logic [CTR_BITS-1:0]   r_pht    [PHT_DEPTH];

  logic                  w_ready, w_btb_we, w_fwd, w_hit, w_taken;
  logic [IDX-1:0]        w_f_idx, w_u_idx;
  logic [TAG_BITS-1:0]   w_f_tag, w_u_tag;
  logic [N-1:0]          w_f_pidx, w_u_pidx;
  logic [CTR_BITS-1:0]   w_f_ctr, w_u_ctr, w_u_ctr_next;
  bt_type_e              w_f_type;
  logic [31:0]           w_btb_tgt;
  logic                  w_unused_pc;

  assign w_unused_pc = ^{pc_i[1:0], pc_i[31:TAG_LSB+TAG_BITS],
                         upd_pc_i[1:0], upd_pc_i[31:TAG_LSB+TAG_BITS]};

  // Init FSM: sweeps the PHT once after reset, then stays in READY.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BP_INIT:  if (r_cnt == CNT_LAST) w_state_next = BP_READY;
      BP_READY: w_state_next = BP_READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= BP_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == BP_INIT) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign w_ready     = (r_state == BP_READY);
  assign ready_o     = w_ready;
  assign dbg_state_o = r_state;

  assign w_f_idx  = pc_i[2 +: IDX];
  assign w_f_tag  = pc_i[TAG_LSB +: TAG_BITS];
  assign w_u_idx  = upd_pc_i[2 +: IDX];
  assign w_u_tag  = upd_pc_i[TAG_LSB +: TAG_BITS];
  assign w_f_pidx = pc_i[2 +: N] ^ r_ghr;
  assign w_u_pidx = upd_pc_i[2 +: N] ^ upd_ghr_i;
  assign w_f_ctr  = r_pht[w_f_pidx];

  assign w_btb_we = w_ready && upd_valid_i && upd_taken_i;
  assign w_fwd    = w_btb_we && (w_u_idx == w_f_idx) && (w_u_tag == w_f_tag);

  // A same-entry, same-tag write this cycle is visible to the fetch immediately.
  always_comb begin
    w_f_type  = r_type[w_f_idx];
    w_btb_tgt = r_target[w_f_idx];
    w_hit     = w_ready && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    if (w_fwd) begin
      w_f_type  = bt_type_e'(upd_type_i);
      w_btb_tgt = upd_target_i;
      w_hit     = 1'b1;
    end
  end

  always_comb begin
    w_taken = 1'b0;
    if (w_hit) w_taken = (w_f_type == BT_BRANCH) ? w_f_ctr[CTR_BITS-1] : 1'b1;
  end

  assign hit_o   = w_hit;
  assign taken_o = w_taken;
  assign ghr_o   = r_ghr;

`ifdef BPRED_RAS_EN
  logic        w_ras_push, w_ras_pop, w_ras_empty;
  logic [31:0] w_ras_top;

  assign w_ras_push = fetch_valid_i && w_hit && (w_f_type == BT_CALL);
  assign w_ras_pop  = fetch_valid_i && w_hit && (w_f_type == BT_RET);

  ucsbece154b_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .push_i      (w_ras_push),
    .pop_i       (w_ras_pop),
    .push_data_i (pc_i + 32'd4),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty)
  );

  always_comb begin
    target_o = '0;
    if (w_hit) target_o = (w_f_type == BT_RET && !w_ras_empty) ? w_ras_top : w_btb_tgt;
  end
`else
  localparam int RAS_DEPTH_UNUSED = RAS_DEPTH;
  assign target_o = w_hit ? w_btb_tgt : '0;
`endif

  // Mispredict repair wins over a same-cycle speculative shift.
  always_comb begin
    w_ghr_next = r_ghr;
    if (w_ready) begin
      if (upd_valid_i && upd_mispredict_i)
        w_ghr_next = (upd_type_i == BT_BRANCH) ? {upd_ghr_i[N-2:0], upd_taken_i} : upd_ghr_i;
      else if (fetch_valid_i && w_hit && (w_f_type == BT_BRANCH))
        w_ghr_next = {r_ghr[N-2:0], w_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) r_ghr <= '0;
    else           r_ghr <= w_ghr_next;
  end

  always_comb begin
    w_u_ctr      = r_pht[w_u_pidx];
    w_u_ctr_next = w_u_ctr;
    if (upd_taken_i) begin
      if (w_u_ctr != CTR_MAX) w_u_ctr_next = w_u_ctr + CTR_ONE;
    end else begin
      if (w_u_ctr != '0) w_u_ctr_next = w_u_ctr - CTR_ONE;
    end
  end

  // PHT has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (r_state == BP_INIT)
      r_pht[r_cnt] <= CTR_WNT;
    else if (upd_valid_i && (upd_type_i == BT_BRANCH))
      r_pht[w_u_pidx] <= w_u_ctr_next;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni)     r_valid <= '0;
    else if (w_btb_we) r_valid[w_u_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= upd_target_i;
      r_type[w_u_idx]   <= bt_type_e'(upd_type_i);
    end
  end

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare.sv
// Directed bench for ucsbece154b_bpred_gshare: driver pushes expected outputs,
// a negedge monitor pops and compares. RAS expectations follow BPRED_RAS_EN.
module tb_ucsbece154b_bpred_gshare;

  localparam int W = 40;
  localparam int PHT_N = 32;
  localparam logic [1:0] BR = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        ready_o, dbg_state_o;
  logic        fetch_valid_i;
  logic [31:0] pc_i;
  logic        hit_o, taken_o;
  logic [31:0] target_o;
  logic [4:0]  ghr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [1:0]  upd_type_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [4:0]  upd_ghr_i;
  logic        upd_mispredict_i;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_en;
  int           checks = 0;
  int           failures = 0;

  ucsbece154b_bpred_gshare dut (
    .clk              (clk),
    .reset_ni         (reset_ni),
    .ready_o          (ready_o),
    .dbg_state_o      (dbg_state_o),
    .fetch_valid_i    (fetch_valid_i),
    .pc_i             (pc_i),
    .hit_o            (hit_o),
    .taken_o          (taken_o),
    .target_o         (target_o),
    .ghr_o            (ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_type_i       (upd_type_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_mispredict_i (upd_mispredict_i)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic idle();
    fetch_valid_i    = 1'b0;
    pc_i             = 32'h0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = 32'h0;
    upd_type_i       = 2'b00;
    upd_taken_i      = 1'b0;
    upd_target_i     = 32'h0;
    upd_ghr_i        = 5'h0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                           input logic [31:0] tgt, input logic [4:0] ghr, input logic misp);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_type_i       = typ;
    upd_taken_i      = tk;
    upd_target_i     = tgt;
    upd_ghr_i        = ghr;
    upd_mispredict_i = misp;
  endtask

  task automatic upd_cycle(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                           input logic [31:0] tgt, input logic [4:0] ghr, input logic misp);
    drive_upd(pc, typ, tk, tgt, ghr, misp);
    step();
    idle();
  endtask

  task automatic expect_out(input string nm, input logic rdy, input logic hit, input logic tk,
                            input logic [31:0] tgt, input logic [4:0] ghr);
    exp_q.push_back({rdy, hit, tk, tgt, ghr});
    name_q.push_back(nm);
    chk_en = 1'b1;
  endtask

  task automatic check_fetch(input string nm, input logic [31:0] pc, input logic hit,
                             input logic tk, input logic [31:0] tgt, input logic [4:0] ghr);
    pc_i = pc;
    expect_out(nm, 1'b1, hit, tk, tgt, ghr);
    step();
    idle();
  endtask

  // INIT window with junk traffic that must be ignored, then the ready edge.
  task automatic init_phase();
    for (int i = 0; i < PHT_N; i++) begin
      fetch_valid_i = 1'b1;
      pc_i = 32'h40;
      drive_upd(32'h40, BR, 1'b1, 32'h80, 5'b10101, 1'b1);
      expect_out($sformatf("init_%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
      step();
    end
    idle();
    pc_i = 32'h40;
    expect_out("ready_rise", 1'b1, 1'b0, 1'b0, 32'h0, 5'h0);
    step();
    idle();
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] act, exp_v;
    string nm;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        act = {ready_o, hit_o, taken_o, target_o, ghr_o};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL underflow: output sampled with no expectation queued");
        end else begin
          exp_v = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got rdy=%b hit=%b tk=%b tgt=%h ghr=%b, want rdy=%b hit=%b tk=%b tgt=%h ghr=%b",
                     nm, act[39], act[38], act[37], act[36:5], act[4:0],
                     exp_v[39], exp_v[38], exp_v[37], exp_v[36:5], exp_v[4:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [4:0]  ghr_e;
    logic [31:0] ret1_e, ret_wrap_e;
`ifdef BPRED_RAS_EN
    ret1_e     = 32'h104;
    ret_wrap_e = 32'h202C;
`else
    ret1_e     = 32'h900;
    ret_wrap_e = 32'h900;
`endif
    chk_en   = 1'b0;
    reset_ni = 1'b0;
    idle();
    step();
    step();
    fetch_valid_i = 1'b1;
    pc_i = 32'h40;
    expect_out("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    step();
    idle();
    reset_ni = 1'b1;
    init_phase();

    // allocation, direction, jump
    pc_i = 32'h0;
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'h0, 1'b1);
    check_fetch("btb_alloc", 32'h40, 1'b1, 1'b0, 32'h80, 5'b00001);
    upd_cycle(32'h200, JMP, 1'b1, 32'h300, 5'h0, 1'b1);
    check_fetch("pht_taken", 32'h40, 1'b1, 1'b1, 32'h80, 5'h0);
    check_fetch("jump_hit", 32'h200, 1'b1, 1'b1, 32'h300, 5'h0);

    // counter saturation at PHT[16], currently 10
    repeat (4) upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'h0, 1'b0);
    check_fetch("sat_hi", 32'h40, 1'b1, 1'b1, 32'h80, 5'h0);
    upd_cycle(32'h40, BR, 1'b0, 32'h80, 5'h0, 1'b0);
    check_fetch("sat_hi_dec1", 32'h40, 1'b1, 1'b1, 32'h80, 5'h0);
    upd_cycle(32'h40, BR, 1'b0, 32'h80, 5'h0, 1'b0);
    check_fetch("sat_hi_dec2", 32'h40, 1'b1, 1'b0, 32'h80, 5'h0);
    repeat (4) upd_cycle(32'h40, BR, 1'b0, 32'h80, 5'h0, 1'b0);
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'h0, 1'b0);
    check_fetch("sat_lo_inc1", 32'h40, 1'b1, 1'b0, 32'h80, 5'h0);
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'h0, 1'b0);
    check_fetch("sat_lo_inc2", 32'h40, 1'b1, 1'b1, 32'h80, 5'h0);

    // prime PHT[17,19,23,31] to 10 so every speculative shift inserts 1
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'd1, 1'b0);
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'd3, 1'b0);
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'd7, 1'b0);
    upd_cycle(32'h40, BR, 1'b1, 32'h80, 5'd15, 1'b0);
    ghr_e = 5'h0;
    for (int k = 0; k < 5; k++) begin
      fetch_valid_i = 1'b1;
      pc_i = 32'h40;
      expect_out($sformatf("ghr_shift_%0d", k), 1'b1, 1'b1, 1'b1, 32'h80, ghr_e);
      step();
      ghr_e = {ghr_e[3:0], 1'b1};
    end
    fetch_valid_i = 1'b1;
    pc_i = 32'h40;
    drive_upd(32'h40, BR, 1'b0, 32'h80, 5'b00010, 1'b1);
    expect_out("repair_cycle", 1'b1, 1'b1, 1'b0, 32'h80, 5'b11111);
    step();
    idle();
    check_fetch("repair_prio", 32'h40, 1'b1, 1'b0, 32'h80, 5'b00100);

    upd_cycle(32'h60, BR, 1'b0, 32'h700, 5'd4, 1'b0);
    check_fetch("nt_no_alloc", 32'h60, 1'b0, 1'b0, 32'h0, 5'd4);

    // same-cycle write/read forwarding
    drive_upd(32'h48, JMP, 1'b1, 32'h500, 5'd4, 1'b0);
    check_fetch("fwd_same_tag", 32'h48, 1'b1, 1'b1, 32'h500, 5'd4);
    drive_upd(32'h104C, JMP, 1'b1, 32'h600, 5'd4, 1'b0);
    check_fetch("fwd_diff_tag", 32'h4C, 1'b0, 1'b0, 32'h0, 5'd4);
    check_fetch("fwd_written", 32'h104C, 1'b1, 1'b1, 32'h600, 5'd4);
    check_fetch("fwd_kept", 32'h48, 1'b1, 1'b1, 32'h500, 5'd4);

    // call / return
    upd_cycle(32'h100, CALL, 1'b1, 32'h800, 5'd4, 1'b0);
    upd_cycle(32'h184, RET, 1'b1, 32'h900, 5'd4, 1'b0);
    fetch_valid_i = 1'b1;
    check_fetch("call_hit", 32'h100, 1'b1, 1'b1, 32'h800, 5'd4);
    fetch_valid_i = 1'b1;
    check_fetch("ret_target", 32'h184, 1'b1, 1'b1, ret1_e, 5'd4);
    fetch_valid_i = 1'b1;
    check_fetch("ret_empty", 32'h184, 1'b1, 1'b1, 32'h900, 5'd4);
    for (int k = 0; k < 9; k++)
      upd_cycle(32'h2008 + 32'(4 * k), CALL, 1'b1, 32'h3000, 5'd4, 1'b0);
    for (int k = 0; k < 9; k++) begin
      fetch_valid_i = 1'b1;
      pc_i = 32'h2008 + 32'(4 * k);
      step();
    end
    idle();
    fetch_valid_i = 1'b1;
    check_fetch("ret_wrap", 32'h184, 1'b1, 1'b1, ret_wrap_e, 5'd4);

    // reset again, and once more in the middle of INIT
    reset_ni = 1'b0;
    pc_i = 32'h40;
    expect_out("reset2_state", 1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    step();
    idle();
    reset_ni = 1'b1;
    repeat (10) step();
    reset_ni = 1'b0;
    step();
    reset_ni = 1'b1;
    init_phase();

    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
